// File: rtl/dbg_apb_pkg.sv
// Shared definitions for the debug-bus APB responder: register map, CTRL/STATUS
// bit positions, identification and abort constants, and responder FSM states.
package dbg_apb_pkg;

   localparam logic [2:0] DBG_REG_CTRL     = 3'd0;
   localparam logic [2:0] DBG_REG_STATUS   = 3'd1;
   localparam logic [2:0] DBG_REG_PC       = 3'd2;
   localparam logic [2:0] DBG_REG_GPR_IDX  = 3'd3;
   localparam logic [2:0] DBG_REG_GPR_DATA = 3'd4;
   localparam logic [2:0] DBG_REG_ID       = 3'd5;
   localparam logic [2:0] DBG_REG_SCRATCH  = 3'd6;

   localparam int unsigned CTRL_HALT_BIT   = 0;
   localparam int unsigned CTRL_RESUME_BIT = 1;
   localparam int unsigned CTRL_STEP_BIT   = 2;

   localparam int unsigned STATUS_HALTED_BIT   = 0;
   localparam int unsigned STATUS_HALT_REQ_BIT = 1;
   localparam int unsigned STATUS_ERR_BIT      = 2;

   localparam logic [31:0] DBG_ID_DEFAULT    = 32'h7AC1_0001;
   localparam logic [31:0] DBG_ABORT_PATTERN = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RESP,
      ST_GPR_WAIT
   } dbg_state_t;

   function automatic logic [31:0] status_word(input logic halted,
                                               input logic halt_req,
                                               input logic err);
      status_word = '0;
      status_word[STATUS_HALTED_BIT]   = halted;
      status_word[STATUS_HALT_REQ_BIT] = halt_req;
      status_word[STATUS_ERR_BIT]      = err;
   endfunction

endpackage

// File: rtl/dbg_run_ctrl.sv
// Run-control sequencing for the debug responder: halt request level,
// resume/step pulses, and detection of resume attempts on a running core.
module dbg_run_ctrl
   import dbg_apb_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic ctrl_wr,
   input  logic halt,
   input  logic resume,
   input  logic step,
   input  logic core_halted,
   output logic core_halt_req,
   output logic core_resume,
   output logic core_step,
   output logic illegal_resume
);

   logic wants_run;

   // A halt in the same write suppresses resume/step entirely, without error.
   assign wants_run      = ctrl_wr && (resume || step) && !halt;
   assign illegal_resume = wants_run && !core_halted;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         core_halt_req <= 1'b0;
         core_resume   <= 1'b0;
         core_step     <= 1'b0;
      end else begin
         if (ctrl_wr && halt) begin
            core_halt_req <= 1'b1;
         end else if (core_halted) begin
            core_halt_req <= 1'b0;
         end
         core_resume <= wants_run && core_halted;
         core_step   <= wants_run && core_halted && step;
      end
   end

endmodule

// File: rtl/dbg_apb_responder.sv
// Core-side APB responder of the debug bus: decodes transfers into the debug
// register file and sequences GPR accesses against the halted core.
module dbg_apb_responder
   import dbg_apb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned APB_ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned GPR_TIMEOUT    = 16,
   parameter logic [31:0] DBG_ID         = DBG_ID_DEFAULT
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [APB_ADDR_WIDTH-1:0] apb_addr,
   input  logic                      apb_sel,
   input  logic                      apb_enable,
   input  logic                      apb_wr_rd,
   input  logic [DATA_WIDTH-1:0]     apb_wdata,
   output logic                      apb_ready,
   output logic [DATA_WIDTH-1:0]     apb_rdata,
   output logic                      core_halt_req,
   input  logic                      core_halted,
   output logic                      core_resume,
   output logic                      core_step,
   input  logic [ADDR_WIDTH-3:0]     core_pc,
   output logic                      gpr_rd_en,
   output logic                      gpr_wr_en,
   output logic [4:0]                gpr_idx,
   output logic [31:0]               gpr_wr_data,
   input  logic [31:0]               gpr_rd_data,
   input  logic                      gpr_rd_valid
);

   localparam int unsigned CNT_W = $clog2(GPR_TIMEOUT + 1);

   dbg_state_t            state;
   dbg_state_t            state_nxt;
   logic [2:0]            word;
   logic                  access;
   logic                  rd_acc;
   logic                  wr_acc;
   logic                  is_gpr;
   logic                  gpr_denied;
   logic                  timeout_hit;
   logic                  gpr_abort;
   logic                  ctrl_wr;
   logic                  illegal_resume;
   logic [CNT_W-1:0]      gpr_cnt;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [DATA_WIDTH-1:0] rd_mux;
   logic [4:0]            idx_q;
   logic [31:0]           scratch;
   logic                  err;
   logic                  unused_ok;

   assign word        = apb_addr[4:2];
   assign unused_ok   = ^apb_addr;
   assign access      = (state == ST_IDLE) && apb_sel && apb_enable;
   assign rd_acc      = access && !apb_wr_rd;
   assign wr_acc      = access && apb_wr_rd;
   assign is_gpr      = (word == DBG_REG_GPR_DATA);
   assign gpr_denied  = access && is_gpr && !core_halted;
   assign timeout_hit = (gpr_cnt == CNT_W'(GPR_TIMEOUT - 1));
   assign gpr_abort   = (state == ST_GPR_WAIT) && apb_sel && !gpr_rd_valid && timeout_hit;
   assign ctrl_wr     = wr_acc && (word == DBG_REG_CTRL);

   assign apb_ready = (state == ST_RESP);
   assign apb_rdata = apb_ready ? rdata_q : '0;
   assign gpr_idx   = idx_q;

   dbg_run_ctrl u_run_ctrl (
      .clk            (clk),
      .rst_n          (rst_n),
      .ctrl_wr        (ctrl_wr),
      .halt           (apb_wdata[CTRL_HALT_BIT]),
      .resume         (apb_wdata[CTRL_RESUME_BIT]),
      .step           (apb_wdata[CTRL_STEP_BIT]),
      .core_halted    (core_halted),
      .core_halt_req  (core_halt_req),
      .core_resume    (core_resume),
      .core_step      (core_step),
      .illegal_resume (illegal_resume)
   );

   always_comb begin
      rd_mux = '0;
      case (word)
         DBG_REG_STATUS:  rd_mux = DATA_WIDTH'(status_word(core_halted, core_halt_req, err));
         DBG_REG_PC:      rd_mux = DATA_WIDTH'(32'({core_pc, 2'b00}));
         DBG_REG_GPR_IDX: rd_mux = DATA_WIDTH'(idx_q);
         DBG_REG_ID:      rd_mux = DATA_WIDTH'(DBG_ID);
         DBG_REG_SCRATCH: rd_mux = DATA_WIDTH'(scratch);
         default:         rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (access) begin
               state_nxt = (rd_acc && is_gpr && core_halted) ? ST_GPR_WAIT : ST_RESP;
            end
         end
         ST_RESP: state_nxt = ST_IDLE;
         ST_GPR_WAIT: begin
            // Losing sel abandons the read; late GPR data is simply never captured.
            if (!apb_sel) begin
               state_nxt = ST_IDLE;
            end else if (gpr_rd_valid || timeout_hit) begin
               state_nxt = ST_RESP;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gpr_cnt     <= '0;
         rdata_q     <= '0;
         idx_q       <= '0;
         scratch     <= '0;
         err         <= 1'b0;
         gpr_rd_en   <= 1'b0;
         gpr_wr_en   <= 1'b0;
         gpr_wr_data <= '0;
      end else begin
         gpr_rd_en <= rd_acc && is_gpr && core_halted;
         gpr_wr_en <= wr_acc && is_gpr && core_halted;
         if (wr_acc && is_gpr && core_halted) begin
            gpr_wr_data <= 32'(apb_wdata);
         end
         if (wr_acc && (word == DBG_REG_GPR_IDX)) begin
            idx_q <= apb_wdata[4:0];
         end
         if (wr_acc && (word == DBG_REG_SCRATCH)) begin
            scratch <= 32'(apb_wdata);
         end

         if ((state == ST_GPR_WAIT) && (state_nxt == ST_GPR_WAIT)) begin
            gpr_cnt <= gpr_cnt + 1'b1;
         end else begin
            gpr_cnt <= '0;
         end

         if (rd_acc) begin
            rdata_q <= rd_mux;
         end else if (wr_acc) begin
            rdata_q <= '0;
         end else if ((state == ST_GPR_WAIT) && apb_sel) begin
            if (gpr_rd_valid) begin
               rdata_q <= DATA_WIDTH'(gpr_rd_data);
            end else if (timeout_hit) begin
               rdata_q <= DATA_WIDTH'(DBG_ABORT_PATTERN);
            end
         end

         if (gpr_denied || gpr_abort || illegal_resume) begin
            err <= 1'b1;
         end else if (wr_acc && (word == DBG_REG_STATUS) && apb_wdata[STATUS_ERR_BIT]) begin
            err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dbg_apb_responder.sv
// Directed bench for dbg_apb_responder with a read-data scoreboard.
module tb_dbg_apb_responder;

   localparam int unsigned GPR_TO = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  apb_addr = '0;
   logic        apb_sel = 1'b0;
   logic        apb_enable = 1'b0;
   logic        apb_wr_rd = 1'b0;
   logic [31:0] apb_wdata = '0;
   logic        apb_ready;
   logic [31:0] apb_rdata;
   logic        core_halt_req;
   logic        core_halted = 1'b0;
   logic        core_resume;
   logic        core_step;
   logic [29:0] core_pc = '0;
   logic        gpr_rd_en;
   logic        gpr_wr_en;
   logic [4:0]  gpr_idx;
   logic [31:0] gpr_wr_data;
   logic [31:0] gpr_rd_data = '0;
   logic        gpr_rd_valid = 1'b0;

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   int          ready_cnt = 0;
   int          resume_cnt = 0;
   int          step_cnt = 0;
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   logic [4:0]  rd_idx = '0;
   logic [31:0] wr_val = '0;

   dbg_apb_responder #(
      .ADDR_WIDTH     (32),
      .APB_ADDR_WIDTH (5),
      .DATA_WIDTH     (32),
      .GPR_TIMEOUT    (GPR_TO),
      .DBG_ID         (32'h7AC1_0001)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .apb_addr      (apb_addr),
      .apb_sel       (apb_sel),
      .apb_enable    (apb_enable),
      .apb_wr_rd     (apb_wr_rd),
      .apb_wdata     (apb_wdata),
      .apb_ready     (apb_ready),
      .apb_rdata     (apb_rdata),
      .core_halt_req (core_halt_req),
      .core_halted   (core_halted),
      .core_resume   (core_resume),
      .core_step     (core_step),
      .core_pc       (core_pc),
      .gpr_rd_en     (gpr_rd_en),
      .gpr_wr_en     (gpr_wr_en),
      .gpr_idx       (gpr_idx),
      .gpr_wr_data   (gpr_wr_data),
      .gpr_rd_data   (gpr_rd_data),
      .gpr_rd_valid  (gpr_rd_valid)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (apb_ready) ready_cnt++;
      if (core_resume) resume_cnt++;
      if (core_resume && core_step) step_cnt++;
      if (gpr_rd_en) begin
         rd_cnt++;
         rd_idx = gpr_idx;
      end
      if (gpr_wr_en) begin
         wr_cnt++;
         wr_val = gpr_wr_data;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic xfer(input logic [4:0] a, input logic wr, input logic [31:0] wd,
                       input string tag, output int lat);
      logic        got;
      logic [31:0] exp;
      got = 1'b0;
      lat = 0;
      @(posedge clk); #1;
      apb_sel = 1'b1; apb_addr = a; apb_wr_rd = wr; apb_wdata = wd; apb_enable = 1'b0;
      @(posedge clk); #1;
      apb_enable = 1'b1;
      @(posedge clk);
      while (!got && lat < 64) begin
         @(negedge clk);
         lat++;
         if (apb_ready) got = 1'b1;
      end
      check({tag, "_ready"}, 32'(got), 32'd1);
      if (got && !wr) begin
         exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
         check({tag, "_rdata"}, apb_rdata, exp);
      end
      @(posedge clk); #1;
      apb_sel = 1'b0; apb_enable = 1'b0; apb_wr_rd = 1'b0;
      @(negedge clk);
      check({tag, "_pulse"}, 32'(apb_ready), 32'd0);
   endtask

   task automatic wr_reg(input logic [4:0] a, input logic [31:0] d, input string tag);
      int lat;
      xfer(a, 1'b1, d, tag, lat);
      check({tag, "_lat"}, lat, 1);
   endtask

   task automatic rd_reg(input logic [4:0] a, input logic [31:0] exp, input string tag);
      int lat;
      exp_q.push_back(exp);
      xfer(a, 1'b0, '0, tag, lat);
      check({tag, "_lat"}, lat, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "global timeout");
   end

   initial begin
      int lat;
      int base_a;
      int base_b;

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_ready", 32'(apb_ready), 0);
      check("rst_rdata", apb_rdata, 0);
      check("rst_halt_req", 32'(core_halt_req), 0);
      check("rst_resume", 32'({core_resume, core_step}), 0);
      check("rst_gpr_en", 32'({gpr_rd_en, gpr_wr_en}), 0);
      check("rst_gpr_idx", 32'(gpr_idx), 0);
      check("rst_gpr_wdata", gpr_wr_data, 0);

      rd_reg(5'h14, 32'h7AC1_0001, "id");
      wr_reg(5'h14, 32'h1111_2222, "id_wr");
      rd_reg(5'h14, 32'h7AC1_0001, "id_ro");
      rd_reg(5'h00, 32'h0, "ctrl_rd");

      wr_reg(5'h18, 32'hA5A5_5A5A, "scr_wr");
      rd_reg(5'h18, 32'hA5A5_5A5A, "scr_rd");
      wr_reg(5'h1C, 32'hFFFF_FFFF, "rsv_wr");
      rd_reg(5'h1C, 32'h0, "rsv_rd");

      // reset asserted while a SCRATCH read is in its access phase
      base_a = ready_cnt;
      @(posedge clk); #1;
      apb_sel = 1'b1; apb_addr = 5'h18; apb_wr_rd = 1'b0;
      @(posedge clk); #1;
      apb_enable = 1'b1;
      #3 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      apb_sel = 1'b0; apb_enable = 1'b0; rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_mid_no_ready", ready_cnt - base_a, 0);
      rd_reg(5'h18, 32'h0, "scr_after_rst");

      base_a = resume_cnt;
      wr_reg(5'h00, 32'h2, "resume_running");
      check("resume_running_cnt", resume_cnt - base_a, 0);
      rd_reg(5'h04, 32'h4, "status_err");
      wr_reg(5'h04, 32'h4, "status_w1c");
      rd_reg(5'h04, 32'h0, "status_clr");

      base_a = wr_cnt;
      base_b = rd_cnt;
      wr_reg(5'h10, 32'h1357_9BDF, "gprw_running");
      rd_reg(5'h10, 32'h0, "gprr_running");
      check("gprw_running_cnt", wr_cnt - base_a, 0);
      check("gprr_running_cnt", rd_cnt - base_b, 0);
      rd_reg(5'h04, 32'h4, "status_gpr_err");
      wr_reg(5'h04, 32'h4, "status_w1c2");

      core_pc = 30'h0ABC_DEF1;
      rd_reg(5'h08, 32'h2AF3_7BC4, "pc");

      wr_reg(5'h00, 32'h1, "halt");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("halt_req_hold", 32'(core_halt_req), 1);
      end
      @(posedge clk); #1 core_halted = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("halt_req_clear", 32'(core_halt_req), 0);
      rd_reg(5'h04, 32'h1, "status_halted");

      wr_reg(5'h0C, 32'hFFFF_FFE7, "idx_wr");
      rd_reg(5'h0C, 32'h7, "idx_rd");

      base_a = rd_cnt;
      exp_q.push_back(32'h0000_1234);
      fork
         xfer(5'h10, 1'b0, '0, "gpr_rd", lat);
         begin
            for (int n = 0; n < 20 && !gpr_rd_en; n++) @(negedge clk);
            repeat (3) @(posedge clk);
            #1 gpr_rd_valid = 1'b1; gpr_rd_data = 32'h0000_1234;
            @(posedge clk);
            #1 gpr_rd_valid = 1'b0; gpr_rd_data = '0;
         end
      join
      check("gpr_rd_en_cnt", rd_cnt - base_a, 1);
      check("gpr_rd_idx", 32'(rd_idx), 7);

      base_a = wr_cnt;
      wr_reg(5'h10, 32'hCAFE_F00D, "gpr_wr");
      check("gpr_wr_en_cnt", wr_cnt - base_a, 1);
      check("gpr_wr_data", wr_val, 32'hCAFE_F00D);

      base_a = resume_cnt;
      base_b = step_cnt;
      wr_reg(5'h00, 32'h6, "step");
      @(negedge clk);
      check("step_resume_cnt", resume_cnt - base_a, 1);
      check("step_step_cnt", step_cnt - base_b, 1);
      base_a = resume_cnt;
      wr_reg(5'h00, 32'h3, "halt_resume");
      @(negedge clk);
      check("halt_wins_cnt", resume_cnt - base_a, 0);
      rd_reg(5'h04, 32'h1, "status_after_step");

      // GPR read abandoned by dropping sel; late data must not surface
      base_a = ready_cnt;
      base_b = rd_cnt;
      @(posedge clk); #1;
      apb_sel = 1'b1; apb_addr = 5'h10; apb_wr_rd = 1'b0;
      @(posedge clk); #1;
      apb_enable = 1'b1;
      repeat (3) @(posedge clk);
      #1 apb_sel = 1'b0; apb_enable = 1'b0;
      repeat (2) @(posedge clk);
      #1 gpr_rd_valid = 1'b1; gpr_rd_data = 32'h5555_5555;
      @(posedge clk);
      #1 gpr_rd_valid = 1'b0; gpr_rd_data = '0;
      repeat (2) @(negedge clk);
      check("abandon_no_ready", ready_cnt - base_a, 0);
      check("abandon_rd_en", rd_cnt - base_b, 1);
      rd_reg(5'h04, 32'h1, "status_after_abandon");

      exp_q.push_back(32'hDEAD_BEEF);
      xfer(5'h10, 1'b0, '0, "gpr_timeout", lat);
      check("gpr_timeout_lat", lat, GPR_TO + 1);
      rd_reg(5'h04, 32'h5, "status_timeout_err");
      wr_reg(5'h04, 32'h4, "status_w1c3");
      rd_reg(5'h04, 32'h1, "status_cleared");

      check("scoreboard_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
